// File: rtl/calc_cmd_arbiter.sv
`default_nettype none
// ==== calc_cmd_arbiter: round-robin share of one calculator core between two token streams ====
// ==== Rev 1.0 ====
module calc_cmd_arbiter #(
  parameter int         GAP_CYCLES = 10,
  parameter int         STALL_MAX  = 255,
  parameter logic [3:0] IDLE_CMD   = 4'hD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_tok,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_tok,
  output logic       req1_ready,
  input  logic [1:0] calc_status,
  output logic [3:0] cmd,
  output logic [1:0] grant,
  output logic       done,
  output logic       abort,
  output logic       err_flag
);

  localparam int         GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam int         STALL_W    = $clog2(STALL_MAX + 1);
  localparam logic [3:0] TOK_EQUALS = 4'hE;
  localparam logic [1:0] STAT_ERROR = 2'b00;
  localparam logic [1:0] STAT_READY = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_GAP       = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [1:0]           grant_nx;
  logic [3:0]           cmd_nx;
  logic                 done_nx, abort_nx, err_nx;
  logic                 last_served, last_served_nx;  // 1 when req1 was served last
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nx;
  logic [STALL_W-1:0]   stall_cnt, stall_cnt_nx;
  logic                 last_was_eq, last_was_eq_nx;

  logic                 owner_valid;
  logic [3:0]           owner_tok;
  logic                 owner_idx;
  logic [STALL_W-1:0]   stall_inc;
  logic                 core_error, core_ready;

  assign core_error  = (calc_status == STAT_ERROR);
  assign core_ready  = (calc_status == STAT_READY);
  assign owner_idx   = grant[1];
  assign owner_valid = (grant[0] & req0_valid) | (grant[1] & req1_valid);
  assign owner_tok   = grant[1] ? req1_tok : req0_tok;
  assign stall_inc   = stall_cnt + STALL_W'(1);

  assign req0_ready  = (state == S_ISSUE) && grant[0];
  assign req1_ready  = (state == S_ISSUE) && grant[1];

  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    cmd_nx         = IDLE_CMD;
    done_nx        = 1'b0;
    abort_nx       = 1'b0;
    err_nx         = err_flag;
    last_served_nx = last_served;
    gap_cnt_nx     = gap_cnt;
    stall_cnt_nx   = stall_cnt;
    last_was_eq_nx = last_was_eq;

    case (state)
      S_IDLE: begin
        if (core_ready && (req0_valid || req1_valid)) begin
          state_nx     = S_ISSUE;
          stall_cnt_nx = '0;
          if (req0_valid && req1_valid)
            grant_nx = last_served ? 2'b01 : 2'b10;
          else if (req0_valid)
            grant_nx = 2'b01;
          else
            grant_nx = 2'b10;
        end
      end

      S_ISSUE: begin
        if (owner_valid) begin
          cmd_nx         = owner_tok;
          gap_cnt_nx     = GAP_W'(GAP_CYCLES);
          stall_cnt_nx   = '0;
          last_was_eq_nx = (owner_tok == TOK_EQUALS);
          state_nx       = S_GAP;
        end else if (stall_inc == STALL_W'(STALL_MAX)) begin
          grant_nx       = 2'b00;
          abort_nx       = 1'b1;
          last_served_nx = owner_idx;
          stall_cnt_nx   = '0;
          state_nx       = S_IDLE;
        end else begin
          stall_cnt_nx = stall_inc;
        end
      end

      // Counter holds 1 in the last gap cycle, giving exactly GAP_CYCLES idle cycles.
      S_GAP: begin
        gap_cnt_nx = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1))
          state_nx = last_was_eq ? S_WAIT_DONE : S_ISSUE;
      end

      S_WAIT_DONE: begin
        if (core_ready) begin
          grant_nx       = 2'b00;
          done_nx        = 1'b1;
          last_served_nx = owner_idx;
          state_nx       = S_IDLE;
        end
      end

      S_ERR: begin
        grant_nx = 2'b00;
        err_nx   = 1'b1;
      end

      default: begin
        state_nx = S_IDLE;
        grant_nx = 2'b00;
      end
    endcase

    // A core error outranks every other transition once an expression is in flight.
    if (core_error && (state != S_IDLE)) begin
      state_nx = S_ERR;
      grant_nx = 2'b00;
      cmd_nx   = IDLE_CMD;
      done_nx  = 1'b0;
      abort_nx = 1'b0;
      err_nx   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= 2'b00;
      cmd         <= IDLE_CMD;
      done        <= 1'b0;
      abort       <= 1'b0;
      err_flag    <= 1'b0;
      last_served <= 1'b1;
      gap_cnt     <= '0;
      stall_cnt   <= '0;
      last_was_eq <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      cmd         <= cmd_nx;
      done        <= done_nx;
      abort       <= abort_nx;
      err_flag    <= err_nx;
      last_served <= last_served_nx;
      gap_cnt     <= gap_cnt_nx;
      stall_cnt   <= stall_cnt_nx;
      last_was_eq <= last_was_eq_nx;
    end
  end

endmodule
`default_nettype wire

// File: doc/calc_cmd_arbiter.md
Name: calc_cmd_arbiter

Overview:
- Shares one calculator core between two command requesters; each requester submits a whole expression as a stream of 4-bit tokens.
- Grants the core to one requester per expression, round-robin.
- Drives the core's cmd bus: each token is presented for exactly one cycle, followed by a fixed idle gap that covers the core's digit-print phase.
- Watches the core's status to detect completion and the error lock-up.

Parameters:
- GAP_CYCLES, 10, number of cycles cmd holds IDLE_CMD after each issued token (minimum 1).
- STALL_MAX, 255, cycles an owner may leave valid low mid-expression before its grant is revoked (minimum 1).
- IDLE_CMD, 4'hD, token value driven on cmd when no token is being issued.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- req0_valid  input  1  requester 0 has a token
- req0_tok  input  4  requester 0 token (0-9 digit, A add, B sub, C mul, E equals, F backspace)
- req0_ready  output  1  requester 0 token accepted this cycle
- req1_valid  input  1  requester 1 has a token
- req1_tok  input  4  requester 1 token
- req1_ready  output  1  requester 1 token accepted this cycle
- calc_status  input  2  core status: 00 error, 01 ready, 10 busy
- cmd  output  4  command to core, registered
- grant  output  2  one-hot current owner, 00 when none
- done  output  1  one-cycle pulse: owner's expression completed
- abort  output  1  one-cycle pulse: owner's grant revoked by stall timeout
- err_flag  output  1  sticky core-error indication

Behaviour:
- Reset values: cmd=IDLE_CMD; grant=00; done=0; abort=0; err_flag=0; state=IDLE; rr pointer favours req0; gap and stall counters 0.
- Reset mid-expression abandons the expression immediately; no done or abort pulse is produced.
- Handshake: reqN_ready = (state==ISSUE) && grant[N]. A transfer is valid && ready in the same cycle.
- A non-owner's ready is always 0. Its valid may stay high indefinitely; its token must be held stable until accepted.
- State machine:
  - IDLE: cmd=IDLE_CMD.
    - If calc_status==01 and any valid: set grant to the winner next edge and go to ISSUE.
    - If both are valid, the winner is the requester opposite the last one served.
    - If only one is valid, it wins regardless of the pointer.
    - If calc_status is not 01: stay in IDLE, grant nothing.
  - ISSUE:
    - On transfer: cmd<=tok at that edge, so cmd shows the token for exactly the following cycle; gap counter loads GAP_CYCLES; go to GAP.
    - If the owner's valid is low, the stall counter increments. When it reaches STALL_MAX: grant<=00, abort pulses, pointer advances past the owner, go to IDLE.
    - The stall counter clears on every transfer.
  - GAP: cmd=IDLE_CMD; counter decrements each cycle. At 0:
    - If the last token was 4'hE, go to WAIT_DONE.
    - Otherwise go back to ISSUE.
  - WAIT_DONE: cmd=IDLE_CMD, grant held, no timeout (multiply latency is unbounded). On the first cycle calc_status==01: grant<=00, done pulses, pointer advances past the owner, go to IDLE.
  - ERR: grant=00, both ready=0, cmd=IDLE_CMD, err_flag=1.
    - Entered from any non-IDLE state when calc_status==00.
    - Held until reset; error takes priority over every other transition in the same cycle.
- Token values are not checked by the arbiter; illegal tokens are forwarded as-is, and the core reports the error through calc_status.
- Latency: at least 1 + GAP_CYCLES cycles between consecutive accepted tokens. Grant appears 1 cycle after the IDLE decision.
- cmd, grant, done, abort and err_flag are all registered.

Test Plan:
- Single expression, GAP_CYCLES=10: req0 sends 3, A, 4, E; status pulses busy then ready. Required: cmd shows 3, A, 4, E each for one cycle, 11 cycles apart; IDLE_CMD in between; done pulses once; grant returns to 00.
- Contention: both valid from reset. Required: grant=01 first. After req0's done, grant=10 while req0 is still valid. The third grant goes back to 01.
- Stall, STALL_MAX=5: req1 owns and sends 7, then drops valid. Required: after 5 ISSUE cycles with valid low, abort pulses, grant=00, and a pending req0 is granted next.
- Core error: calc_status forced to 00 during GAP. Required: next cycle err_flag=1, grant=00, ready=0. This holds until reset; after reset all outputs return to reset values.
- Not ready: calc_status=10 while req0 is valid in IDLE. Required: no grant. Grant follows 1 cycle after status becomes 01.
- Reset asserted in WAIT_DONE. Required: grant=00, cmd=IDLE_CMD, and no done pulse.
